dl_buffer: RTL and testbench
============================

DL_BUFFER -- requirements
Module: dl_buffer

Interface
REQ-001 Parameter WIDTH, default 8, sets the data path width in bits (minimum 1).
REQ-002 Parameter DEPTH, default 4, sets the write-queue entries; it SHALL be a power of two, minimum 2.
REQ-003 Port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port nRES  input  1  asynchronous active-low reset.
REQ-005 Port cs_n  input  1  when 1, the core is disconnected from the ASIC data bus.
REQ-006 Port res  input  WIDTH  ALU result.
REQ-007 Port res_load  input  1  push res into the write queue and into dl.
REQ-008 Port rd_req  input  1  one-cycle pulse requesting capture of dbus_in into dl.
REQ-009 Port dbus_in  input  WIDTH  ASIC data bus, sampled value.
REQ-010 Port dbus_out  output  WIDTH  value driven onto the ASIC data bus.
REQ-011 Port dbus_oe  output  1  drive enable for dbus_out.
REQ-012 Port bus_ack  input  1  ASIC accepts the driven word this cycle.
REQ-013 Port dl  output  WIDTH  current latch value.
REQ-014 Port empty, full  output  1 each  write-queue status.
REQ-015 Port level  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-016 The write queue SHALL be a FIFO of DEPTH x WIDTH; res_load with full=0 pushes res; the head is visible on dbus_out.
REQ-017 res_load with full=1 SHALL not change the queue; dl still loads res.
REQ-018 The bus FSM SHALL have the states IDLE, DRIVE and SAMPLE.
REQ-019 dbus_oe SHALL be 1 only in DRIVE, and dbus_out SHALL be 0 outside DRIVE.
REQ-020 IDLE->DRIVE when empty=0 and cs_n=0; IDLE->SAMPLE when a read is pending, empty=1 and cs_n=0; reads are serviced only with the queue empty.
REQ-021 In DRIVE with bus_ack=1, the head SHALL be popped; next state is DRIVE if entries remain and cs_n=0, otherwise IDLE.
REQ-022 DRIVE with cs_n=1 SHALL go to IDLE next cycle with oe deasserted; the head is not popped. cs_n takes priority over bus_ack in the same cycle.
REQ-023 rd_req in any state SHALL set a one-deep pending flag; further rd_req while pending are merged.
REQ-024 In SAMPLE, dl SHALL load dbus_in and the pending flag SHALL clear, then the FSM returns to IDLE; read latency from an idle, empty start is 2 cycles (rd_req edge -> SAMPLE -> dl updated).
REQ-025 When a SAMPLE capture and res_load occur in the same cycle, dl SHALL take res; the read completes and clears its pending flag.
REQ-026 Simultaneous push and pop SHALL keep level constant; push on empty and pop on full SHALL be legal.
REQ-027 Pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-028 empty, full and level SHALL be combinational from the registered pointers.

Reset
REQ-029 nRES=0 SHALL asynchronously force: FSM=IDLE, queue empty (level=0), pending flag 0, dl=0, dbus_oe=0, dbus_out=0.
REQ-030 Reset during DRIVE SHALL drop dbus_oe immediately and discard all queued entries.
REQ-031 Deassertion SHALL take effect on the first rising CLK edge after nRES=1.

Configuration
REQ-032 With macro DL_OVF_STICKY_EN defined, the block SHALL add input ovf_clr (1 bit) and output ovf (1 bit). ovf is set by res_load while full=1, cleared by ovf_clr (set wins), and reset to 0.
REQ-033 Without DL_OVF_STICKY_EN, those ports and their logic SHALL be absent and the behaviour is otherwise identical.

Structure
REQ-034 Package dl_pkg SHALL hold the FSM state enum (IDLE, DRIVE, SAMPLE) and the default constants DL_WIDTH_DEF=8 and DL_DEPTH_DEF=4.
REQ-035 The queue SHALL be the sub-module dl_fifo (parameters WIDTH and DEPTH; push, pop, head, empty, full, level); the FSM and dl register stay in dl_buffer.

Verification
REQ-036 Push 0x11, 0x22, 0x33 with cs_n=0 and bus_ack high every DRIVE cycle -> dbus_out shows 0x11, 0x22, 0x33 on consecutive cycles with dbus_oe=1, then IDLE and empty=1.
REQ-037 Push 5 words at DEPTH=4 with cs_n=1 -> full=1, level=4, the fifth word is dropped and dl=fifth value; ovf=1 when DL_OVF_STICKY_EN is defined.
REQ-038 In DRIVE with head 0xA5, assert cs_n=1 together with bus_ack -> next cycle IDLE, dbus_oe=0, level unchanged; with cs_n=0, 0xA5 is re-driven.
REQ-039 rd_req with dbus_in=0x5A while the queue holds 2 words -> both words drain first, then SAMPLE, and dl=0x5A.
REQ-040 nRES pulsed low mid-DRIVE with level=3 -> dbus_oe=0 immediately, level=0, dl=0, and the FSM is IDLE after release.

Source files
------------

// File: rtl/dl_pkg.sv
// +--------------------------------------------------------------------+
// | dl_pkg : shared bus-FSM state encoding and default sizes            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package dl_pkg;

   localparam int DL_WIDTH_DEF = 8;
   localparam int DL_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2
   } dl_state_e;

endpackage

`default_nettype wire

// File: rtl/dl_fifo.sv
// +--------------------------------------------------------------------+
// | dl_fifo : DEPTH x WIDTH write queue, head word always visible       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dl_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     nRES,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

   // Pointers carry one extra bit so full and empty stay distinguishable.
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             w_push;
   logic             w_pop;

   assign level  = wr_q - rd_q;
   assign empty  = (wr_q == rd_q);
   assign full   = (level == FULL_LVL);
   assign head   = mem_q[rd_q[AW-1:0]];

   assign w_push = push & ~full;
   assign w_pop  = pop  & ~empty;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (w_push) wr_d = wr_q + 1'b1;
      if (w_pop)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/dl_buffer.sv
// +--------------------------------------------------------------------+
// | dl_buffer : data latch plus write queue and ASIC bus FSM            |
// | Option DL_OVF_STICKY_EN adds sticky overflow flag (ovf / ovf_clr)   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dl_buffer
   import dl_pkg::*;
#(
   parameter int WIDTH = DL_WIDTH_DEF,
   parameter int DEPTH = DL_DEPTH_DEF
) (
   input  logic                     CLK,
   input  logic                     nRES,
   input  logic                     cs_n,
   input  logic [WIDTH-1:0]         res,
   input  logic                     res_load,
   input  logic                     rd_req,
   input  logic [WIDTH-1:0]         dbus_in,
   output logic [WIDTH-1:0]         dbus_out,
   output logic                     dbus_oe,
   input  logic                     bus_ack,
   output logic [WIDTH-1:0]         dl,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
`ifdef DL_OVF_STICKY_EN
   ,
   input  logic                     ovf_clr,
   output logic                     ovf
`endif
);

   localparam int             LW      = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0]  LVL_ONE = LW'(1);

   dl_state_e        state_q, state_d;
   logic             pending_q, pending_d;
   logic [WIDTH-1:0] dl_q, dl_d;
   logic [WIDTH-1:0] w_head;
   logic             w_pop;
   logic             w_push_ok;
   logic             w_remain;

   dl_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .nRES  (nRES),
      .push  (res_load),
      .pop   (w_pop),
      .din   (res),
      .head  (w_head),
      .empty (empty),
      .full  (full),
      .level (level)
   );

   assign w_push_ok = res_load & ~full;
   // A word pushed while the last one is acked keeps the bus in DRIVE.
   assign w_remain  = (level != LVL_ONE) | w_push_ok;

   always_comb begin
      state_d = state_q;
      w_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!cs_n) begin
               if (!empty)         state_d = DRIVE;
               else if (pending_q) state_d = SAMPLE;
            end
         end
         DRIVE: begin
            if (cs_n) begin
               state_d = IDLE;
            end else if (bus_ack) begin
               w_pop = 1'b1;
               if (!w_remain) state_d = IDLE;
            end
         end
         SAMPLE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pending_d = (state_q == SAMPLE) ? 1'b0 : (pending_q | rd_req);
      dl_d      = dl_q;
      if (res_load)               dl_d = res;
      else if (state_q == SAMPLE) dl_d = dbus_in;
   end

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         dl_q      <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         dl_q      <= dl_d;
      end
   end

   assign dbus_oe  = (state_q == DRIVE);
   assign dbus_out = dbus_oe ? w_head : '0;
   assign dl       = dl_q;

`ifdef DL_OVF_STICKY_EN
   logic ovf_q, ovf_d;

   assign ovf_d = (res_load & full) | (ovf_q & ~ovf_clr);

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dl_buffer.sv
// +--------------------------------------------------------------------+
// | tb_dl_buffer : directed + random checks of dl_buffer vs queue model |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dl_buffer;

   localparam int W = 8;
   localparam int D = 4;

   logic          CLK = 1'b0;
   logic          nRES;
   logic          cs_n;
   logic [W-1:0]  res;
   logic          res_load;
   logic          rd_req;
   logic [W-1:0]  dbus_in;
   logic [W-1:0]  dbus_out;
   logic          dbus_oe;
   logic          bus_ack;
   logic [W-1:0]  dl;
   logic          empty;
   logic          full;
   logic [2:0]    level;
   logic          clr_v;
`ifdef DL_OVF_STICKY_EN
   logic          ovf_clr;
   logic          ovf;
   assign ovf_clr = clr_v;
`endif

   always #5 CLK = ~CLK;

   dl_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .CLK      (CLK),
      .nRES     (nRES),
      .cs_n     (cs_n),
      .res      (res),
      .res_load (res_load),
      .rd_req   (rd_req),
      .dbus_in  (dbus_in),
      .dbus_out (dbus_out),
      .dbus_oe  (dbus_oe),
      .bus_ack  (bus_ack),
      .dl       (dl),
      .empty    (empty),
      .full     (full),
      .level    (level)
`ifdef DL_OVF_STICKY_EN
      ,
      .ovf_clr  (ovf_clr),
      .ovf      (ovf)
`endif
   );

   // Reference: queue of words, bus phase (0 idle, 1 driving, 2 sampling).
   logic [W-1:0] q[$];
   int           mode;
   bit           pend;
   logic [W-1:0] m_dl;
   bit           m_ovf;

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mode  = 0;
      pend  = 1'b0;
      m_dl  = '0;
      m_ovf = 1'b0;
   endtask

   task automatic model_step();
      int  sz;
      int  nm;
      bit  push_ok;
      bit  pop;
      sz      = q.size();
      push_ok = res_load && (sz < D);
      pop     = 1'b0;
      nm      = mode;
      case (mode)
         0: begin
            if (!cs_n && sz > 0)  nm = 1;
            else if (!cs_n && pend) nm = 2;
         end
         1: begin
            if (cs_n) nm = 0;
            else if (bus_ack) begin
               pop = 1'b1;
               nm  = ((sz - 1 + int'(push_ok)) > 0) ? 1 : 0;
            end
         end
         default: nm = 0;
      endcase
      if (res_load)       m_dl = res;
      else if (mode == 2) m_dl = dbus_in;
      pend = (mode == 2) ? 1'b0 : (pend | rd_req);
      if (res_load && sz == D) m_ovf = 1'b1;
      else if (clr_v)          m_ovf = 1'b0;
      if (pop)     void'(q.pop_front());
      if (push_ok) q.push_back(res);
      mode = nm;
   endtask

   task automatic check_all();
      logic [W-1:0] exp_out;
      exp_out = '0;
      if (mode == 1) exp_out = q[0];
      chk("dbus_oe",  dbus_oe,  (mode == 1));
      chk("dbus_out", dbus_out, exp_out);
      chk("empty",    empty,    (q.size() == 0));
      chk("full",     full,     (q.size() == D));
      chk("level",    level,    q.size());
      chk("dl",       dl,       m_dl);
`ifdef DL_OVF_STICKY_EN
      chk("ovf",      ovf,      m_ovf);
`endif
   endtask

   task automatic cyc(input logic c, input logic rl, input logic [W-1:0] r, input logic rq,
                      input logic [W-1:0] din, input logic ack, input logic clr);
      cs_n     = c;
      res_load = rl;
      res      = r;
      rd_req   = rq;
      dbus_in  = din;
      bus_ack  = ack;
      clr_v    = clr;
      @(posedge CLK);
      if (nRES) model_step();
      else      model_reset();
      @(negedge CLK);
      check_all();
   endtask

   initial begin
      nRES = 1'b0;
      cs_n = 1'b1; res = '0; res_load = 1'b0; rd_req = 1'b0;
      dbus_in = '0; bus_ack = 1'b0; clr_v = 1'b0;
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      check_all();
      nRES = 1'b1;

      // Three pushes drained back-to-back with continuous ack.
      cyc(0, 1, 8'h11, 0, 8'h00, 1, 0);
      cyc(0, 1, 8'h22, 0, 8'h00, 1, 0);
      cyc(0, 1, 8'h33, 0, 8'h00, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 0, 8'h00, 1, 0);
      chk("drain_empty", empty, 1'b1);

      // Overfill with bus deselected: fifth word dropped, dl takes it.
      cyc(1, 1, 8'hA5, 0, 8'h00, 0, 0);
      cyc(1, 1, 8'h02, 0, 8'h00, 0, 0);
      cyc(1, 1, 8'h03, 0, 8'h00, 0, 0);
      cyc(1, 1, 8'h04, 0, 8'h00, 0, 0);
      cyc(1, 1, 8'h05, 0, 8'h00, 0, 0);
      chk("ovfl_level", level, 3'd4);
      chk("ovfl_dl",    dl,    8'h05);

      // Deselect in DRIVE beats ack; head is re-driven afterwards.
      cyc(0, 0, 8'h00, 0, 8'h00, 0, 0);
      chk("head_a5", dbus_out, 8'hA5);
      cyc(1, 0, 8'h00, 0, 8'h00, 1, 0);
      chk("desel_oe",    dbus_oe, 1'b0);
      chk("desel_level", level,   3'd4);
      cyc(0, 0, 8'h00, 0, 8'h00, 0, 1);
      chk("redrive_a5", dbus_out, 8'hA5);
      for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 0, 8'h00, 1, 0);

      // Read waits for the queue to drain, then samples.
      cyc(1, 1, 8'h61, 0, 8'h00, 0, 0);
      cyc(1, 1, 8'h62, 0, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 1, 8'h5A, 1, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 0, 8'h5A, 1, 0);
      chk("read_dl", dl, 8'h5A);

      // Asynchronous reset in the middle of DRIVE.
      cyc(1, 1, 8'h71, 0, 8'h00, 0, 0);
      cyc(1, 1, 8'h72, 0, 8'h00, 0, 0);
      cyc(1, 1, 8'h73, 0, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 0, 8'h00, 0, 0);
      chk("pre_rst_oe", dbus_oe, 1'b1);
      #2 nRES = 1'b0;
      #1 model_reset();
      check_all();
      chk("rst_level", level, 3'd0);
      @(posedge CLK);
      @(negedge CLK);
      check_all();
      nRES = 1'b1;
      cyc(0, 0, 8'h00, 0, 8'h00, 0, 0);
      cyc(0, 1, 8'h81, 0, 8'h00, 1, 0);
      cyc(0, 0, 8'h00, 0, 8'h00, 1, 0);

      // Randomised traffic against the queue model.
      for (int i = 0; i < 2000; i++) begin
         cyc(($urandom % 4) == 0,
             ($urandom % 3) == 0,
             W'($urandom),
             ($urandom % 8) == 0,
             W'($urandom),
             ($urandom % 3) != 0,
             ($urandom % 16) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
